// File: rtl/kuznechik_key_schedule.sv
// Iterative Kuznechik (GOST R 34.12-2015) key expansion: 256-bit master key in,
// ten 128-bit round keys out, ITER_PER_CYCLE Feistel iterations per clock.
module kuznechik_key_schedule #(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [255:0]  key,
  output logic          busy,
  output logic          keys_valid,
  output logic [1279:0] round_keys
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] STEP = 6'(ITER_PER_CYCLE);

  // Byte k holds the linear-layer coefficient applied to input byte k.
  localparam logic [127:0] LCOEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

  localparam logic [2047:0] PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};

  generate
    if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2 &&
        ITER_PER_CYCLE != 4 && ITER_PER_CYCLE != 8) begin : g_bad_iter
      $error("kuznechik_key_schedule: ITER_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'd0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  // Sixteen R steps: the new byte enters at the top, byte 0 falls off.
  function automatic logic [127:0] l_transform(input logic [127:0] w);
    logic [127:0] s;
    logic [7:0]   acc;
    s = w;
    for (int r = 0; r < 16; r++) begin
      acc = 8'd0;
      for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(LCOEF[8*k +: 8], s[8*k +: 8]);
      s = {acc, s[127:8]};
    end
    return s;
  endfunction

  function automatic logic [127:0] s_transform(input logic [127:0] w);
    logic [127:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = PI[8*(255 - int'(w[8*k +: 8])) +: 8];
    return s;
  endfunction

  function automatic logic [255:0] feistel(input logic [255:0] st, input logic [7:0] idx);
    logic [127:0] c;
    c = l_transform({120'd0, idx});
    return {l_transform(s_transform(st[255:128] ^ c)) ^ st[127:0], st[255:128]};
  endfunction

  state_t       state, state_next;
  logic [127:0] a1, a0;
  logic [255:0] ab_next;
  logic [5:0]   iter, iter_last;
  logic         accept;

  assign iter_last = iter + STEP - 6'd1;
  assign accept    = in_valid & in_ready;

  always_comb begin
    ab_next = {a1, a0};
    for (int n = 0; n < ITER_PER_CYCLE; n++) ab_next = feistel(ab_next, 8'(iter) + 8'(n));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (iter_last == 6'd32) state_next = DONE;
      end
      DONE: begin
        in_ready   = ~rst;
        keys_valid = 1'b1;
        if (in_valid) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Round-key pairs are latched on the edge that completes iterations 8, 16, 24, 32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1         <= '0;
      a0         <= '0;
      iter       <= '0;
      round_keys <= '0;
    end else if (accept) begin
      a1         <= key[255:128];
      a0         <= key[127:0];
      iter       <= 6'd1;
      round_keys <= {1024'd0, key[127:0], key[255:128]};
    end else if (state == RUN) begin
      a1   <= ab_next[255:128];
      a0   <= ab_next[127:0];
      iter <= iter + STEP;
      for (int k = 1; k <= 4; k++) begin
        if (iter_last == 6'(8*k)) begin
          round_keys[256*k +: 128]       <= ab_next[255:128];
          round_keys[256*k + 128 +: 128] <= ab_next[127:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_kuznechik_key_schedule.sv
// Bench for kuznechik_key_schedule: one instance per legal ITER_PER_CYCLE, checked
// against a byte-array reference model of the key schedule and the published vector.
module tb_kuznechik_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [3:0]    iv;
  logic [255:0]  key;
  logic [3:0]    rdy, bsy, kv;
  logic [1279:0] rk [4];

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] STD_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] STD_K1  = 128'h8899aabbccddeeff0011223344556677;
  localparam logic [127:0] STD_K2  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] STD_K3  = 128'hdb31485315694343228d6aef8cc78c44;
  localparam logic [127:0] STD_K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

  localparam logic [127:0] PI_ROWS [16] = '{
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};

  localparam int COEF [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      kuznechik_key_schedule #(.ITER_PER_CYCLE(1 << g)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (iv[g]),
        .in_ready   (rdy[g]),
        .key        (key),
        .busy       (bsy[g]),
        .keys_valid (kv[g]),
        .round_keys (rk[g])
      );
    end
  endgenerate

  // Reference model: carry-less product then polynomial reduction by 0x1C3.
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h01C3 << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] refL(input logic [127:0] w);
    logic [7:0]   a [16];
    logic [7:0]   acc;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) a[k] = w[8*k +: 8];
    for (int r = 0; r < 16; r++) begin
      acc = 8'd0;
      for (int k = 0; k < 16; k++) acc = acc ^ refMul(8'(COEF[k]), a[k]);
      for (int k = 0; k < 15; k++) a[k] = a[k+1];
      a[15] = acc;
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[8*k +: 8] = a[k];
    return res;
  endfunction

  function automatic logic [127:0] refS(input logic [127:0] w);
    logic [127:0] res;
    logic [7:0]   x;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      x = w[8*k +: 8];
      res[8*k +: 8] = PI_ROWS[x[7:4]][8*(15 - int'(x[3:0])) +: 8];
    end
    return res;
  endfunction

  function automatic logic [1279:0] refExpand(input logic [255:0] mk);
    logic [127:0]  a1, a0, t;
    logic [1279:0] out;
    a1  = mk[255:128];
    a0  = mk[127:0];
    out = '0;
    out[127:0]   = a1;
    out[255:128] = a0;
    for (int i = 1; i <= 32; i++) begin
      t  = refL(refS(a1 ^ refL(128'(i)))) ^ a0;
      a0 = a1;
      a1 = t;
      if (i % 8 == 0) begin
        out[128*(i/4) +: 128]     = a1;
        out[128*(i/4 + 1) +: 128] = a0;
      end
    end
    return out;
  endfunction

  function automatic logic [255:0] randKey();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [127:0] bit128(input logic x);
    return {127'd0, x};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic checkKeys(input int d, input string tag, input logic [1279:0] exp);
    for (int k = 0; k < 10; k++)
      checkOutput($sformatf("%s_i%0d_K%0d", tag, 1 << d, k + 1), rk[d][128*k +: 128], exp[128*k +: 128]);
  endtask

  // Presents a key for one accepting edge; returns #1 after that edge.
  task automatic applyStimulus(input int d, input logic [255:0] k, input bit hold, input string tag);
    @(negedge clk);
    checkOutput($sformatf("%s_i%0d_ready", tag, 1 << d), bit128(rdy[d]), 128'd1);
    iv[d] = 1'b1;
    key   = k;
    @(posedge clk);
    #1;
    if (!hold) iv[d] = 1'b0;
    key = randKey();
    checkOutput($sformatf("%s_i%0d_busy", tag, 1 << d), bit128(bsy[d]), 128'd1);
    checkOutput($sformatf("%s_i%0d_kvlow", tag, 1 << d), bit128(kv[d]), 128'd0);
    checkOutput($sformatf("%s_i%0d_notready", tag, 1 << d), bit128(rdy[d]), 128'd0);
  endtask

  task automatic waitDone(input int d, input string tag);
    int n;
    n = 0;
    while (kv[d] !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("%s_i%0d_latency", tag, 1 << d), 128'(n), 128'(32 >> d));
    checkOutput($sformatf("%s_i%0d_idlebusy", tag, 1 << d), bit128(bsy[d]), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1279:0] stdExp, snap;
    logic [255:0]  k2;
    int            rkDiff, kvDiff, busyDiff;

    rst = 1'b1;
    iv  = '0;
    key = '0;
    stdExp = refExpand(STD_KEY);
    #2;
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("rst_i%0d_ready", 1 << d), bit128(rdy[d]), 128'd0);
      checkOutput($sformatf("rst_i%0d_busy", 1 << d), bit128(bsy[d]), 128'd0);
      checkOutput($sformatf("rst_i%0d_kv", 1 << d), bit128(kv[d]), 128'd0);
      checkKeys(d, "rst", '0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++)
      checkOutput($sformatf("postrst_i%0d_ready", 1 << d), bit128(rdy[d]), 128'd1);

    for (int d = 0; d < 4; d++) begin
      $display("[TB] ITER_PER_CYCLE=%0d", 1 << d);

      applyStimulus(d, STD_KEY, 1'b0, "std");
      waitDone(d, "std");
      checkKeys(d, "std", stdExp);
      checkOutput($sformatf("vec_i%0d_K1", 1 << d), rk[d][127:0], STD_K1);
      checkOutput($sformatf("vec_i%0d_K2", 1 << d), rk[d][255:128], STD_K2);
      checkOutput($sformatf("vec_i%0d_K3", 1 << d), rk[d][383:256], STD_K3);
      checkOutput($sformatf("vec_i%0d_K10", 1 << d), rk[d][1279:1152], STD_K10);

      // in_valid held through the run with a different key waiting on the bus
      k2 = randKey();
      applyStimulus(d, STD_KEY, 1'b1, "hold");
      key = k2;
      waitDone(d, "hold1");
      checkKeys(d, "hold1", stdExp);
      @(posedge clk);
      #1;
      iv[d] = 1'b0;
      checkOutput($sformatf("hold_i%0d_kvdrop", 1 << d), bit128(kv[d]), 128'd0);
      checkOutput($sformatf("hold_i%0d_busy", 1 << d), bit128(bsy[d]), 128'd1);
      checkOutput($sformatf("hold_i%0d_K1", 1 << d), rk[d][127:0], k2[255:128]);
      waitDone(d, "hold2");
      checkKeys(d, "hold2", refExpand(k2));

      applyStimulus(d, '0, 1'b0, "zero");
      checkOutput($sformatf("zero_i%0d_K1", 1 << d), rk[d][127:0], 128'd0);
      checkOutput($sformatf("zero_i%0d_K2", 1 << d), rk[d][255:128], 128'd0);
      checkOutput($sformatf("zero_i%0d_K10clr", 1 << d), rk[d][1279:1152], 128'd0);
      waitDone(d, "zero");
      checkKeys(d, "zero", refExpand('0));

      snap = rk[d];
      rkDiff = 0;
      kvDiff = 0;
      busyDiff = 0;
      repeat (100) begin
        @(posedge clk);
        #1;
        if (rk[d] !== snap) rkDiff++;
        if (kv[d] !== 1'b1) kvDiff++;
        if (bsy[d] !== 1'b0) busyDiff++;
      end
      checkOutput($sformatf("idle_i%0d_rkchanges", 1 << d), 128'(rkDiff), 128'd0);
      checkOutput($sformatf("idle_i%0d_kvdrops", 1 << d), 128'(kvDiff), 128'd0);
      checkOutput($sformatf("idle_i%0d_busyrises", 1 << d), 128'(busyDiff), 128'd0);

      // asynchronous reset while iteration 17 is pending
      applyStimulus(d, STD_KEY, 1'b0, "arst");
      repeat (16 >> d) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput($sformatf("arst_i%0d_busy", 1 << d), bit128(bsy[d]), 128'd0);
      checkOutput($sformatf("arst_i%0d_kv", 1 << d), bit128(kv[d]), 128'd0);
      checkOutput($sformatf("arst_i%0d_ready", 1 << d), bit128(rdy[d]), 128'd0);
      checkKeys(d, "arst", '0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(d, STD_KEY, 1'b0, "rerun");
      waitDone(d, "rerun");
      checkKeys(d, "rerun", stdExp);

      repeat (3) begin
        k2 = randKey();
        applyStimulus(d, k2, 1'b0, "rand");
        waitDone(d, "rand");
        checkKeys(d, "rand", refExpand(k2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
